// File: rtl/clk_div_multi_pkg.sv
// clk_div_multi_pkg
//   Shared types and helpers for the multi-channel clock divider.
//   - ch_state_e : per-channel state (DISABLED / RUN)
//   - MIN_DIV    : smallest divide value a channel will run with
//   - clamp_div  : maps divide requests of 0 and 1 up to MIN_DIV
package clk_div_multi_pkg;

  localparam int unsigned MIN_DIV   = 2;
  // Widest divide value clamp_div handles; channel widths must not exceed it.
  localparam int unsigned MAX_DIV_W = 16;

  typedef enum logic {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } ch_state_e;

  function automatic logic [MAX_DIV_W-1:0] clamp_div(input logic [MAX_DIV_W-1:0] v);
    return (v < MAX_DIV_W'(MIN_DIV)) ? MAX_DIV_W'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/clk_div_multi_ch.sv
// clk_div_ch
//   One divider channel: state, cycle counter, divide-value handshake and
//   registered divided clock. High phase lasts div/2 cycles; the extra
//   cycle of an odd divide goes to the low phase.
//   Optional macro CLK_DIV_MULTI_GLITCHFREE_STOP_EN: when en_i falls during
//   a high phase, the channel finishes that high phase before stopping.
//
//   state    | meaning
//   DISABLED | idle, cnt=0, clk_o=0, divide value always accepted
//   RUN      | counting; clk_o high while cnt < div/2
//
// Ports:
//   clk_i, rst_ni  source clock, synchronous active-low reset
//   en_i           channel enable
//   sync_i         restart the period (cnt=0, clk_o=1)
//   div_i          requested divide value, div_valid_i / div_ready_o handshake
//   clk_o          divided clock (registered)
//   cnt_o          current cycle counter
module clk_div_ch
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             clk_o,
  output logic [DIV_W-1:0] cnt_o
);

  localparam logic [DIV_W-1:0] RST_DIV =
    DIV_W'(clamp_div(MAX_DIV_W'(DIV_W'(DEFAULT_DIV))));

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_q, clk_d;

  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] div_clamped;
  logic             wrap;

  assign half        = div_q >> 1;
  assign cnt_inc     = cnt_q + DIV_W'(1);
  assign wrap        = (cnt_q == div_q - DIV_W'(1));
  assign div_clamped = DIV_W'(clamp_div(MAX_DIV_W'(div_i)));

  // Ready only at period boundaries so a period never mixes two divide values.
  assign div_ready_o = rst_ni & ((state_q == DISABLED) | wrap | sync_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clk_d   = clk_q;
    div_d   = div_q;

    if (div_valid_i && div_ready_o) begin
      div_d = div_clamped;
    end

    case (state_q)
      DISABLED: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
        end
      end
      RUN: begin
        if (!en_i) begin
`ifdef CLK_DIV_MULTI_GLITCHFREE_STOP_EN
          // Finish the high phase; sync and wrap are ignored while stopping.
          if (clk_q && (cnt_inc < half)) begin
            cnt_d = cnt_inc;
            clk_d = 1'b1;
          end else begin
            state_d = DISABLED;
            cnt_d   = '0;
            clk_d   = 1'b0;
          end
`else
          state_d = DISABLED;
          cnt_d   = '0;
          clk_d   = 1'b0;
`endif
        end else if (sync_i || wrap) begin
          cnt_d = '0;
          clk_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < half);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= DISABLED;
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      clk_q   <= clk_d;
    end
  end

  assign clk_o = clk_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi
//   NUM_CH independent integer clock dividers sharing one source clock and
//   one phase-align pulse. Channel c uses bus slices [c*W +: W].
//   Optional macro CLK_DIV_MULTI_GLITCHFREE_STOP_EN (see clk_div_ch).
//
// Ports:
//   clk_i, rst_ni     source clock, synchronous active-low reset
//   en_i              per-channel enable
//   sync_i            restart all running channels together
//   div_i             per-channel divide value
//   div_valid_i       per-channel divide-value valid
//   div_ready_o       per-channel divide-value ready
//   clk_o             per-channel divided clock (registered)
//   cycl_count_o      per-channel cycle counter
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int unsigned NUM_CH            = 4,
  parameter int unsigned DIV_VALUE_WIDTH   = 4,
  parameter int unsigned DEFAULT_DIV_VALUE = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_CH-1:0]                 en_i,
  input  logic                              sync_i,
  input  logic [NUM_CH*DIV_VALUE_WIDTH-1:0] div_i,
  input  logic [NUM_CH-1:0]                 div_valid_i,
  output logic [NUM_CH-1:0]                 div_ready_o,
  output logic [NUM_CH-1:0]                 clk_o,
  output logic [NUM_CH*DIV_VALUE_WIDTH-1:0] cycl_count_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    clk_div_ch #(
      .DIV_W       (DIV_VALUE_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV_VALUE)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i[c]),
      .sync_i      (sync_i),
      .div_i       (div_i[c*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH]),
      .div_valid_i (div_valid_i[c]),
      .div_ready_o (div_ready_o[c]),
      .clk_o       (clk_o[c]),
      .cnt_o       (cycl_count_o[c*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  logic        clk = 1'b0;
  logic        rst_n, sync;
  logic [3:0]  en, dval, dready, clk_o;
  logic [15:0] div, cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per channel running flag, position in period, divide, output level
  int m_run[4], m_pos[4], m_div[4], m_hi[4];
  logic [3:0] exp_rdy;

  always #5 clk = ~clk;

  clk_div_multi dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .sync_i       (sync),
    .div_i        (div),
    .div_valid_i  (dval),
    .div_ready_o  (dready),
    .clk_o        (clk_o),
    .cycl_count_o (cnt_o)
  );

  function automatic int clampv(int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    for (int c = 0; c < 4; c++)
      r[c] = rst_n && (m_run[c] == 0 || m_pos[c] == m_div[c] - 1 || sync);
    return r;
  endfunction

  function automatic logic [3:0] exp_clk();
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (m_run[c] != 0) && (m_hi[c] != 0);
    return r;
  endfunction

  function automatic logic [15:0] exp_cnt();
    logic [15:0] r;
    for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(m_pos[c]);
    return r;
  endfunction

  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      int nd;
      if (!rst_n) begin
        m_run[c] = 0; m_pos[c] = 0; m_div[c] = 2; m_hi[c] = 0;
      end else begin
        nd = m_div[c];
        if (dval[c] && (m_run[c] == 0 || m_pos[c] == m_div[c] - 1 || sync))
          nd = clampv(int'(div[c*4 +: 4]));
        if (m_run[c] == 0) begin
          if (en[c]) begin m_run[c] = 1; m_pos[c] = 0; m_hi[c] = 1; end
        end else if (!en[c]) begin
`ifdef CLK_DIV_MULTI_GLITCHFREE_STOP_EN
          if (m_hi[c] != 0 && m_pos[c] + 1 < m_div[c] / 2) m_pos[c]++;
          else begin m_run[c] = 0; m_pos[c] = 0; m_hi[c] = 0; end
`else
          m_run[c] = 0; m_pos[c] = 0; m_hi[c] = 0;
`endif
        end else if (sync || m_pos[c] == m_div[c] - 1) begin
          m_pos[c] = 0; m_hi[c] = 1;
        end else begin
          m_pos[c]++;
          m_hi[c] = (m_pos[c] < m_div[c] / 2) ? 1 : 0;
        end
        m_div[c] = nd;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] e, input logic s,
                       input logic [3:0] v, input logic [15:0] d);
    @(negedge clk);
    rst_n = r; en = e; sync = s; dval = v; div = d;
    #1;
    exp_rdy = exp_ready();
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 16'h0);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 4'hF, 1'b1, 4'hF, 16'hFFFF);
    n_tests++;
    if (dready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", dready); end
    tick();
    n_tests++;
    if (clk_o !== 4'b0000) begin n_fail++; $display("FAIL reset_clk: got %b expected 0000", clk_o); end
    n_tests++;
    if (cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", cnt_o); end
  endtask

  task automatic test_default_div2();
    logic [3:0] e_clk;
    do_reset();
    drive(1'b1, 4'b0001, 1'b0, 4'h0, 16'h0);
    n_tests++;
    if (dready !== 4'b1111) begin n_fail++; $display("FAIL div2_ready_idle: got %b expected 1111", dready); end
    tick();
    n_tests++;
    if (clk_o !== 4'b0001 || cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL div2_first: got clk %b cnt %h expected 0001/0000", clk_o, cnt_o);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b0001, 1'b0, 4'h0, 16'h0);
      n_tests++;
      if (dready !== {3'b111, (i % 2 == 1)}) begin
        n_fail++; $display("FAIL div2_ready[%0d]: got %b expected %b", i, dready, {3'b111, (i % 2 == 1)});
      end
      tick();
      e_clk = ((i + 1) % 2 == 0) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (clk_o !== e_clk || cnt_o !== 16'((i + 1) % 2)) begin
        n_fail++; $display("FAIL div2_run[%0d]: got clk %b cnt %h expected %b/%h", i, clk_o, cnt_o, e_clk, 16'((i + 1) % 2));
      end
    end
  endtask

  task automatic test_div_values();
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 4'b0010, 16'h0050); tick();
    drive(1'b1, 4'b0010, 1'b0, 4'h0, 16'h0050); tick();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (clk_o[1] !== (i % 5 < 2) || cnt_o[7:4] !== 4'(i % 5)) begin
        n_fail++; $display("FAIL div5[%0d]: got clk %b cnt %0d expected %b/%0d", i, clk_o[1], cnt_o[7:4], (i % 5 < 2), i % 5);
      end
      drive(1'b1, 4'b0010, 1'b0, 4'h0, 16'h0050); tick();
    end
    for (int i = 0; i < 3; i++) begin drive(1'b1, 4'h0, 1'b0, 4'h0, 16'h0); tick(); end
    drive(1'b1, 4'h0, 1'b0, 4'b0010, 16'h00F0); tick();
    drive(1'b1, 4'b0010, 1'b0, 4'h0, 16'h00F0); tick();
    for (int i = 0; i < 30; i++) begin
      n_tests++;
      if (clk_o[1] !== (i % 15 < 7) || cnt_o[7:4] !== 4'(i % 15)) begin
        n_fail++; $display("FAIL div15[%0d]: got clk %b cnt %0d expected %b/%0d", i, clk_o[1], cnt_o[7:4], (i % 15 < 7), i % 15);
      end
      drive(1'b1, 4'b0010, 1'b0, 4'h0, 16'h00F0); tick();
    end
  endtask

  task automatic test_mid_period_change();
    int   e_cnt[9] = '{2, 3, 0, 1, 2, 3, 4, 5, 0};
    logic e_clk[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    logic e_rdy[9] = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    logic [3:0] v;
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 4'b0100, 16'h0400); tick();
    drive(1'b1, 4'b0100, 1'b0, 4'h0, 16'h0400); tick();
    drive(1'b1, 4'b0100, 1'b0, 4'h0, 16'h0400); tick();
    for (int i = 0; i < 9; i++) begin
      v = (i <= 2) ? 4'b0100 : 4'b0000;
      drive(1'b1, 4'b0100, 1'b0, v, 16'h0600);
      n_tests++;
      if (dready[2] !== e_rdy[i]) begin
        n_fail++; $display("FAIL midchg_ready[%0d]: got %b expected %b", i, dready[2], e_rdy[i]);
      end
      tick();
      n_tests++;
      if (cnt_o[11:8] !== 4'(e_cnt[i]) || clk_o[2] !== e_clk[i]) begin
        n_fail++; $display("FAIL midchg_run[%0d]: got cnt %0d clk %b expected %0d/%b", i, cnt_o[11:8], clk_o[2], e_cnt[i], e_clk[i]);
      end
    end
  endtask

  task automatic test_sync();
    int n;
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 4'hF, 16'h5432); tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h5432); tick();
    n = int'($urandom_range(3, 9));
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h5432);
      n_tests++;
      if (dready !== exp_rdy) begin n_fail++; $display("FAIL sync_pre_ready[%0d]: got %b expected %b", i, dready, exp_rdy); end
      tick();
      n_tests++;
      if (clk_o !== exp_clk() || cnt_o !== exp_cnt()) begin
        n_fail++; $display("FAIL sync_pre[%0d]: got clk %b cnt %h expected %b/%h", i, clk_o, cnt_o, exp_clk(), exp_cnt());
      end
    end
    drive(1'b1, 4'hF, 1'b1, 4'h0, 16'h5432);
    n_tests++;
    if (dready !== 4'hF) begin n_fail++; $display("FAIL sync_ready: got %b expected 1111", dready); end
    tick();
    n_tests++;
    if (clk_o !== 4'hF || cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL sync_align: got clk %b cnt %h expected 1111/0000", clk_o, cnt_o);
    end
  endtask

  task automatic test_clamp();
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 4'b0011, 16'h0077); tick();
    drive(1'b1, 4'h0, 1'b0, 4'b0011, 16'h0010); tick();
    drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h0); tick();
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (clk_o !== ((i % 2 == 0) ? 4'hF : 4'h0) || cnt_o !== ((i % 2 == 0) ? 16'h0 : 16'h1111)) begin
        n_fail++; $display("FAIL clamp[%0d]: got clk %b cnt %h", i, clk_o, cnt_o);
      end
      drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h0); tick();
    end
  endtask

  task automatic test_stop_and_reset();
`ifdef CLK_DIV_MULTI_GLITCHFREE_STOP_EN
    logic e_clk[5] = '{1, 1, 0, 0, 0};
    int   e_cnt[5] = '{2, 3, 0, 0, 0};
`else
    logic e_clk[5] = '{0, 0, 0, 0, 0};
    int   e_cnt[5] = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    drive(1'b1, 4'h0, 1'b0, 4'b1000, 16'h8000); tick();
    drive(1'b1, 4'b1000, 1'b0, 4'h0, 16'h8000); tick();
    drive(1'b1, 4'b1000, 1'b0, 4'h0, 16'h8000); tick();
    n_tests++;
    if (cnt_o[15:12] !== 4'd1 || clk_o[3] !== 1'b1) begin
      n_fail++; $display("FAIL stop_pre: got cnt %0d clk %b expected 1/1", cnt_o[15:12], clk_o[3]);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h0, 1'b0, 4'h0, 16'h8000); tick();
      n_tests++;
      if (clk_o[3] !== e_clk[i] || cnt_o[15:12] !== 4'(e_cnt[i])) begin
        n_fail++; $display("FAIL stop[%0d]: got clk %b cnt %0d expected %b/%0d", i, clk_o[3], cnt_o[15:12], e_clk[i], e_cnt[i]);
      end
    end
    drive(1'b1, 4'h0, 1'b0, 4'hF, 16'h3333); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 4'hF, 1'b0, 4'h0, 16'h0); tick(); end
    drive(1'b0, 4'hF, 1'b0, 4'h0, 16'h0);
    n_tests++;
    if (dready !== 4'h0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0000", dready); end
    tick();
    n_tests++;
    if (clk_o !== 4'h0 || cnt_o !== 16'h0) begin
      n_fail++; $display("FAIL midreset: got clk %b cnt %h expected 0000/0000", clk_o, cnt_o);
    end
  endtask

  task automatic test_random();
    logic       r, s;
    logic [3:0] e, v;
    logic [15:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      e = en; v = dval; d = div;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 7) == 0) e[c] = ~e[c];
        if (!(v[c] && !exp_rdy[c])) begin
          v[c] = ($urandom_range(0, 3) == 0);
          d[c*4 +: 4] = 4'($urandom_range(0, 15));
        end
      end
      drive(r, e, s, v, d);
      n_tests++;
      if (dready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, dready, exp_rdy); end
      tick();
      n_tests++;
      if (clk_o !== exp_clk() || cnt_o !== exp_cnt()) begin
        n_fail++; $display("FAIL rand_out[%0d]: got clk %b cnt %h expected %b/%h", i, clk_o, cnt_o, exp_clk(), exp_cnt());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 4'h0; sync = 1'b0; dval = 4'h0; div = 16'h0;
    exp_rdy = 4'h0;
    for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_pos[c] = 0; m_div[c] = 2; m_hi[c] = 0; end
    test_reset();
    test_default_div2();
    test_div_values();
    test_mid_period_change();
    test_sync();
    test_clamp();
    test_stop_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
